// File: rtl/exe_pipe.sv
// EX stage with a valid/ready EX/MEM output register. The optional shift-add
// multiplier (MUL/MULI) is built only when the macro EXE_MUL_EN is defined.
module exe_pipe #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] NPC_id,
  input  logic [31:0]     IR_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] NPC_ex,
  output logic [31:0]     IR_ex,
  output logic [XLEN-1:0] ALU_res,
  output logic [XLEN-1:0] B_ex,
  output logic            sel,
  output logic            illegal,
  output logic            busy
);

  if ((MUL_BITS == 0) || (XLEN % MUL_BITS != 0)) begin : g_bad_mul_bits
    $error("exe_pipe: MUL_BITS must be non-zero and divide XLEN");
  end

  logic [5:0]      op;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] res_c;
  logic            sel_c;
  logic            ill_c;
  logic            is_mul_c;
  logic            idle_c;
  logic            accept_c;
  logic            mul_done_c;
  logic [XLEN-1:0] mul_res_c;

  assign op = IR_id[31:26];

  // Single-cycle decode and ALU; RI forms (op[4] set) take Imm as second operand.
  always_comb begin
    op_b     = op[4] ? Imm : B;
    res_c    = '0;
    sel_c    = 1'b0;
    ill_c    = 1'b0;
    is_mul_c = 1'b0;
    case (op)
      6'b000000, 6'b010000: res_c = A + op_b;
      6'b000001, 6'b010001: res_c = A - op_b;
      6'b000010, 6'b010010: res_c = A & op_b;
      6'b000011, 6'b010011: res_c = A | op_b;
      6'b000100, 6'b010100: res_c = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(op_b))};
      6'b000101, 6'b010101: begin
`ifdef EXE_MUL_EN
        is_mul_c = 1'b1;
`else
        ill_c = 1'b1;
`endif
      end
      6'b110000, 6'b110001: res_c = A + Imm;
      6'b110100: begin
        res_c = NPC_id + Imm;
        sel_c = (A != '0);
      end
      6'b110101: begin
        res_c = NPC_id + Imm;
        sel_c = (A == '0);
      end
      6'b111111: res_c = '0;
      default:   ill_c = 1'b1;
    endcase
  end

  assign in_ready = idle_c && (!out_valid || out_ready);
  assign accept_c = in_valid && in_ready && !flush;

`ifdef EXE_MUL_EN
  localparam int unsigned STEPS = XLEN / MUL_BITS;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q, acc_nx;
  logic            last_c;

  assign last_c     = (state_q == S_MUL) && (cnt_q == CW'(STEPS - 1));
  assign idle_c     = (state_q == S_IDLE);
  assign busy       = (state_q == S_MUL);
  assign mul_done_c = last_c && !flush;
  assign mul_res_c  = acc_nx;

  // Retire MUL_BITS multiplier bits per step.
  always_comb begin
    acc_nx = acc_q;
    for (int i = 0; i < int'(MUL_BITS); i++) begin
      if (mplier_q[i]) acc_nx = acc_nx + (mcand_q << i);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_c && is_mul_c) state_d = S_MUL;
      S_MUL:   if (last_c) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (accept_c && is_mul_c) begin
      cnt_q    <= '0;
      mcand_q  <= A;
      mplier_q <= op_b;
      acc_q    <= '0;
    end else if (state_q == S_MUL) begin
      cnt_q    <= cnt_q + CW'(1);
      mcand_q  <= mcand_q << MUL_BITS;
      mplier_q <= mplier_q >> MUL_BITS;
      acc_q    <= acc_nx;
    end
  end
`else
  assign idle_c     = 1'b1;
  assign busy       = 1'b0;
  assign mul_done_c = 1'b0;
  assign mul_res_c  = '0;
`endif

  // EX/MEM register; a multiply parks NPC/IR/B here while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      NPC_ex    <= '0;
      IR_ex     <= '0;
      ALU_res   <= '0;
      B_ex      <= '0;
      sel       <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept_c) begin
      NPC_ex <= NPC_id;
      IR_ex  <= IR_id;
      B_ex   <= B;
      if (is_mul_c) begin
        out_valid <= 1'b0;
      end else begin
        ALU_res   <= res_c;
        sel       <= sel_c;
        illegal   <= ill_c;
        out_valid <= 1'b1;
      end
    end else if (mul_done_c) begin
      ALU_res   <= mul_res_c;
      sel       <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
